// File: rtl/orn_sticky.sv
// orn_sticky: sticky OR-combiner with per-channel level/edge detection,
// write-1-to-clear pending flags, a masked OR output with its inverse, and
// a saturating count of newly pending unmasked events with overflow flag.
module orn_sticky #(
  parameter int WIDTH = 3,
  parameter int CNTW  = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] edge_mode,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] pend,
  output logic             q,
  output logic             nq,
  output logic [CNTW-1:0]  cnt,
  output logic             ovf
);

  localparam logic [CNTW-1:0] CNT_ZERO = '0;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Overflow is flagged only when an increment meets a saturated counter.
  function automatic logic sat_hit(input logic [CNTW-1:0] v, input logic inc);
    sat_hit = inc && (v == CNT_MAX);
  endfunction

  logic [WIDTH-1:0] prev_p0;
  logic [WIDTH-1:0] ev_p0;
  logic [WIDTH-1:0] pend_nxt_p0;
  logic [WIDTH-1:0] new_ev_p0;
  logic             inc_p0;
  logic             q_nxt_p0;

  // ---- stage p0: event detection and next-state decode ----
  // Edge channels fire only on 0->1 of i versus the delayed copy; level
  // channels fire every cycle i is high. Set beats clear, so an event in
  // the clear cycle keeps the flag. A channel already pending is not new,
  // which also covers the clear-and-re-set case.
  always_comb begin
    ev_p0       = (i & ~edge_mode) | (i & ~prev_p0 & edge_mode);
    pend_nxt_p0 = ev_p0 | (pend & ~clr);
    new_ev_p0   = ev_p0 & ~pend & mask;
    inc_p0      = |new_ev_p0;
    q_nxt_p0    = |(pend_nxt_p0 & mask);
  end

  // ---- stage p1: registered flags ----
  // Input history, sticky pending flags and the masked OR register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      prev_p0 <= '0;
      pend    <= '0;
      q       <= 1'b0;
    end else begin
      prev_p0 <= i;
      pend    <= pend_nxt_p0;
      q       <= q_nxt_p0;
    end
  end

  // Event counter: clear takes priority but still admits this cycle's event.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt <= CNT_ZERO;
      ovf <= 1'b0;
    end else if (cnt_clr) begin
      cnt <= inc_p0 ? CNT_ONE : CNT_ZERO;
      ovf <= 1'b0;
    end else if (inc_p0) begin
      cnt <= sat_inc(cnt);
      ovf <= ovf | sat_hit(cnt, inc_p0);
    end
  end

  assign nq = ~q;

endmodule

// File: tb/tb_orn_sticky.sv
// Bench for orn_sticky: a channel-by-channel behavioural model checked
// against two instances (8-bit and 2-bit counters) on every falling edge,
// plus literal expectations along a directed scenario.
module tb_orn_sticky;

  logic       ck;
  logic       rst;
  logic [2:0] i, mask, edge_mode, clr;
  logic       cnt_clr;
  logic [2:0] pend_a, pend_b;
  logic       q_a, nq_a, ovf_a, q_b, nq_b, ovf_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  orn_sticky #(.WIDTH(3), .CNTW(8)) dut_a (
    .ck(ck), .rst(rst), .i(i), .mask(mask), .edge_mode(edge_mode), .clr(clr),
    .cnt_clr(cnt_clr), .pend(pend_a), .q(q_a), .nq(nq_a), .cnt(cnt_a), .ovf(ovf_a)
  );

  orn_sticky #(.WIDTH(3), .CNTW(2)) dut_b (
    .ck(ck), .rst(rst), .i(i), .mask(mask), .edge_mode(edge_mode), .clr(clr),
    .cnt_clr(cnt_clr), .pend(pend_b), .q(q_b), .nq(nq_b), .cnt(cnt_b), .ovf(ovf_b)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: per-channel booleans and plain integer counters.
  bit m_prev [3];
  bit m_pend [3];
  bit m_q = 0;
  int m_cnt8 = 0, m_cnt2 = 0;
  bit m_ovf8 = 0, m_ovf2 = 0;

  always @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin m_prev[k] = 0; m_pend[k] = 0; end
      m_q = 0; m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 0; m_ovf2 = 0;
    end else begin
      bit any_new, any_q, ev;
      bit nxt [3];
      any_new = 0; any_q = 0;
      for (int k = 0; k < 3; k++) begin
        if (edge_mode[k]) ev = i[k] && !m_prev[k];
        else              ev = i[k];
        nxt[k] = ev || (m_pend[k] && !clr[k]);
        if (ev && !m_pend[k] && mask[k]) any_new = 1;
        if (nxt[k] && mask[k]) any_q = 1;
      end
      if (cnt_clr) begin
        m_cnt8 = any_new ? 1 : 0; m_cnt2 = any_new ? 1 : 0;
        m_ovf8 = 0; m_ovf2 = 0;
      end else if (any_new) begin
        if (m_cnt8 == 255) m_ovf8 = 1; else m_cnt8++;
        if (m_cnt2 == 3)   m_ovf2 = 1; else m_cnt2++;
      end
      for (int k = 0; k < 3; k++) begin m_pend[k] = nxt[k]; m_prev[k] = i[k]; end
      m_q = any_q;
    end
  end

  function automatic int model_pend();
    return {29'd0, m_pend[2], m_pend[1], m_pend[0]};
  endfunction

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge ck) begin
    chk("pend8", int'(pend_a), model_pend());
    chk("q8",    int'(q_a),    int'(m_q));
    chk("nq8",   int'(nq_a),   int'(!m_q));
    chk("cnt8",  int'(cnt_a),  m_cnt8);
    chk("ovf8",  int'(ovf_a),  int'(m_ovf8));
    chk("pend2", int'(pend_b), model_pend());
    chk("cnt2",  int'(cnt_b),  m_cnt2);
    chk("ovf2",  int'(ovf_b),  int'(m_ovf2));
  end

  task automatic drive(input logic [2:0] vi, input logic [2:0] vm,
                       input logic [2:0] ve, input logic [2:0] vc, input logic vcc);
    i = vi; mask = vm; edge_mode = ve; clr = vc; cnt_clr = vcc;
  endtask

  task automatic tick();
    @(posedge ck);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
    tick(); tick();
    chk("rst_pend", int'(pend_a), 0);
    chk("rst_q",    int'(q_a), 0);
    chk("rst_nq",   int'(nq_a), 1);
    chk("rst_cnt",  int'(cnt_a), 0);
    chk("rst_ovf",  int'(ovf_a), 0);
    rst = 1'b0;
    tick();

    // single level event on channel 1
    drive(3'b010, 3'b111, 3'b000, 3'b000, 1'b0); tick();
    chk("lvl_pend", int'(pend_a), 3'b010);
    chk("lvl_q", int'(q_a), 1);
    chk("lvl_nq", int'(nq_a), 0);
    chk("lvl_cnt", int'(cnt_a), 1);
    drive(3'b000, 3'b111, 3'b000, 3'b000, 1'b0); tick();
    chk("hold_pend", int'(pend_a), 3'b010);
    chk("hold_q", int'(q_a), 1);

    // clear with simultaneous event: set wins, not counted
    drive(3'b010, 3'b111, 3'b000, 3'b010, 1'b0); tick();
    chk("setwin_pend", int'(pend_a), 3'b010);
    chk("setwin_cnt", int'(cnt_a), 1);
    drive(3'b000, 3'b111, 3'b000, 3'b010, 1'b0); tick();
    chk("clr_pend", int'(pend_a), 0);
    chk("clr_q", int'(q_a), 0);

    // edge mode held high: one event total
    for (int n = 0; n < 5; n++) begin
      drive(3'b111, 3'b111, 3'b111, 3'b000, 1'b0); tick();
    end
    chk("edge_pend", int'(pend_a), 3'b111);
    chk("edge_cnt", int'(cnt_a), 2);
    drive(3'b000, 3'b111, 3'b111, 3'b111, 1'b0); tick();
    drive(3'b101, 3'b111, 3'b111, 3'b000, 1'b0); tick();
    chk("edge2_pend", int'(pend_a), 3'b101);
    chk("edge2_cnt", int'(cnt_a), 3);

    // masked channel sets pend but not q/cnt
    drive(3'b000, 3'b111, 3'b000, 3'b111, 1'b0); tick();
    drive(3'b001, 3'b000, 3'b000, 3'b000, 1'b0); tick();
    chk("mask_pend", int'(pend_a), 3'b001);
    chk("mask_q", int'(q_a), 0);
    chk("mask_cnt", int'(cnt_a), 3);
    drive(3'b000, 3'b001, 3'b000, 3'b000, 1'b0); tick();
    chk("unmask_q", int'(q_a), 1);
    chk("unmask_cnt", int'(cnt_a), 3);

    // edge mode with input held: clear is not re-set
    drive(3'b000, 3'b111, 3'b000, 3'b111, 1'b0); tick();
    drive(3'b100, 3'b111, 3'b100, 3'b000, 1'b0); tick();
    chk("edgeh_pend", int'(pend_a), 3'b100);
    drive(3'b100, 3'b111, 3'b100, 3'b100, 1'b0); tick();
    drive(3'b100, 3'b111, 3'b100, 3'b000, 1'b0); tick();
    chk("edgeh_clr", int'(pend_a), 0);
    chk("edgeh_q", int'(q_a), 0);

    // saturation on the 2-bit counter
    drive(3'b000, 3'b111, 3'b000, 3'b000, 1'b1); tick();
    chk("cclr_cnt", int'(cnt_b), 0);
    for (int n = 0; n < 4; n++) begin
      drive(3'b001, 3'b111, 3'b000, 3'b000, 1'b0); tick();
      drive(3'b000, 3'b111, 3'b000, 3'b001, 1'b0); tick();
      if (n == 2) chk("sat3_ovf", int'(ovf_b), 0);
    end
    chk("sat_cnt2", int'(cnt_b), 3);
    chk("sat_ovf2", int'(ovf_b), 1);
    chk("sat_cnt8", int'(cnt_a), 4);
    drive(3'b010, 3'b111, 3'b000, 3'b000, 1'b1); tick();
    chk("cclr_inc_cnt", int'(cnt_b), 1);
    chk("cclr_inc_ovf", int'(ovf_b), 0);

    // build pend=111, cnt=5 then async reset between edges
    drive(3'b000, 3'b111, 3'b000, 3'b111, 1'b0); tick();
    for (int n = 0; n < 4; n++) begin
      drive(3'b111, 3'b111, 3'b000, 3'b000, 1'b0); tick();
      if (n < 3) begin drive(3'b000, 3'b111, 3'b000, 3'b111, 1'b0); tick(); end
    end
    chk("pre_rst_cnt", int'(cnt_a), 5);
    chk("pre_rst_pend", int'(pend_a), 3'b111);
    drive(3'b111, 3'b111, 3'b111, 3'b000, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_pend", int'(pend_a), 0);
    chk("arst_q", int'(q_a), 0);
    chk("arst_nq", int'(nq_a), 1);
    chk("arst_cnt", int'(cnt_a), 0);
    chk("arst_ovf", int'(ovf_a), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_pend", int'(pend_a), 3'b111);
    chk("rel_cnt", int'(cnt_a), 1);

    // mixed traffic, model-checked only
    for (int n = 0; n < 80; n++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
            ($urandom_range(0, 15) == 0));
      tick();
    end

    @(negedge ck);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
